// File: rtl/multi_mem_stage.sv
// multi_mem_stage
//   Fetch/memory stage of the multicycle RV32I datapath: unified word memory,
//   address mux, instruction register, OldPC register, memory data register,
//   a boot/bench loader write port and sticky fault flags.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   pc, result        address sources; adr_src selects result when 1
//   mem_write         store write_data to the addressed word
//   ir_write          capture read_data into instr and pc into old_pc
//   write_data        store data
//   ld_en/ld_addr/ld_data  loader write port (priority over mem_write)
//   err_clr           synchronous clear of the fault flags (set wins)
//   read_data         combinational read of the current address (0 if out of range)
//   instr, old_pc     instruction register and the PC it was fetched from
//   mdr               read_data registered every cycle
//   err_misalign      sticky: access cycle with adr[1:0] != 0
//   err_oor           sticky: access cycle or loader write beyond the memory
module multi_mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] result,
    input  logic        adr_src,
    input  logic        mem_write,
    input  logic        ir_write,
    input  logic [31:0] write_data,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        err_clr,
    output logic [31:0] read_data,
    output logic [31:0] instr,
    output logic [31:0] old_pc,
    output logic [31:0] mdr,
    output logic        err_misalign,
    output logic        err_oor
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    // Byte limit held in 33 bits so the comparison never wraps.
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   adr;
    logic [AW-1:0] idx;
    logic [AW-1:0] ld_idx;
    logic          in_range;
    logic          ld_in_range;
    logic          access;
    logic          mis_set;
    logic          oor_set;

    always_comb begin
        adr         = adr_src ? result : pc;
        idx         = adr[AW+1:2];
        ld_idx      = ld_addr[AW+1:2];
        in_range    = ({1'b0, adr} < LIMIT);
        ld_in_range = ({1'b0, ld_addr} < LIMIT);
        access      = mem_write | ir_write | adr_src;
        mis_set     = access && (adr[1:0] != 2'b00);
        oor_set     = (access && !in_range) || (ld_en && !ld_in_range);
        read_data   = in_range ? mem[idx] : '0;
    end

    // Memory is not reset; rst only inhibits writes at the edge it is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_en) begin
                if (ld_in_range)
                    mem[ld_idx] <= ld_data;
            end else if (mem_write && in_range) begin
                mem[idx] <= write_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr        <= NOP_INSTR;
            old_pc       <= '0;
            mdr          <= '0;
            err_misalign <= 1'b0;
            err_oor      <= 1'b0;
        end else begin
            mdr <= read_data;
            if (ir_write) begin
                instr  <= read_data;
                old_pc <= pc;
            end
            if (mis_set)
                err_misalign <= 1'b1;
            else if (err_clr)
                err_misalign <= 1'b0;
            if (oor_set)
                err_oor <= 1'b1;
            else if (err_clr)
                err_oor <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_mem_stage.sv
// tb_multi_mem_stage
//   Directed-vector bench for multi_mem_stage. Inputs change 1 time unit after
//   the rising edge; outputs are sampled 1 time unit after that.
module tb_multi_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, result, write_data, ld_addr, ld_data;
    logic        adr_src, mem_write, ir_write, ld_en, err_clr;
    logic [31:0] read_data, instr, old_pc, mdr;
    logic        err_misalign, err_oor;

    int n_checks = 0;
    int n_pass   = 0;

    multi_mem_stage #(
        .DEPTH_WORDS(1024),
        .NOP_INSTR  (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .result      (result),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .write_data  (write_data),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .err_clr     (err_clr),
        .read_data   (read_data),
        .instr       (instr),
        .old_pc      (old_pc),
        .mdr         (mdr),
        .err_misalign(err_misalign),
        .err_oor     (err_oor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance past the next rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Combinational read through the result path, no access cycle side effects
    // other than misalign/oor for the given address.
    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        adr_src = 1'b1;
        result  = a;
        #1;
        chk(tag, read_data, exp);
        adr_src = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc = '0; result = '0; write_data = '0; ld_addr = '0; ld_data = '0;
        adr_src = 1'b0; mem_write = 1'b0; ir_write = 1'b0; ld_en = 1'b0; err_clr = 1'b0;

        // 1. Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst_instr",  instr, 32'h00000013);
        chk("rst_old_pc", old_pc, 32'h0);
        chk("rst_mdr",    mdr, 32'h0);
        chk("rst_mis",    32'(err_misalign), 32'h0);
        chk("rst_oor",    32'(err_oor), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        load(32'h0,  32'h00500093);
        load(32'h4,  32'h00A00113);
        load(32'h10, 32'h12345678);
        load(32'h40, 32'hCAFEF00D);

        // Fetch word 0
        pc = 32'h0; ir_write = 1'b1;
        #1 chk("fetch0_rd", read_data, 32'h00500093);
        tick();
        ir_write = 1'b0;
        chk("fetch0_instr",  instr, 32'h00500093);
        chk("fetch0_old_pc", old_pc, 32'h0);

        // Fetch word 1: old_pc follows pc, mdr follows read_data
        pc = 32'h4; ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
        chk("fetch1_instr",  instr, 32'h00A00113);
        chk("fetch1_old_pc", old_pc, 32'h4);
        chk("fetch1_mdr",    mdr, 32'h00A00113);

        // 2. Store with simultaneous ir_write: reads see pre-write contents
        adr_src = 1'b1; result = 32'h40; write_data = 32'hDEADBEEF;
        mem_write = 1'b1; ir_write = 1'b1;
        #1 chk("st_same_rd", read_data, 32'hCAFEF00D);
        tick();
        mem_write = 1'b0; ir_write = 1'b0;
        chk("st_ir_old",  instr, 32'hCAFEF00D);
        chk("st_mdr_old", mdr, 32'hCAFEF00D);
        chk("st_old_pc",  old_pc, 32'h4);
        chk("st_next_rd", read_data, 32'hDEADBEEF);
        tick();
        chk("st_mdr_new", mdr, 32'hDEADBEEF);
        chk("st_no_mis",  32'(err_misalign), 32'h0);
        chk("st_no_oor",  32'(err_oor), 32'h0);

        // 3. Misaligned access reads the containing word and sets the flag
        result = 32'h42; adr_src = 1'b1;
        #1 chk("mis_rd", read_data, 32'hDEADBEEF);
        tick();
        chk("mis_set", 32'(err_misalign), 32'h1);
        adr_src = 1'b0; pc = 32'h0;
        tick();
        chk("mis_hold", 32'(err_misalign), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("mis_clr", 32'(err_misalign), 32'h0);

        // 4. Out of range store is dropped and flags err_oor
        adr_src = 1'b1; result = 32'h1000; write_data = 32'h55555555; mem_write = 1'b1;
        #1 chk("oor_rd", read_data, 32'h0);
        tick();
        mem_write = 1'b0;
        chk("oor_set",    32'(err_oor), 32'h1);
        chk("oor_no_mis", 32'(err_misalign), 32'h0);
        adr_src = 1'b0;
        peek(32'h0, "oor_no_alias", 32'h00500093);
        // set beats clear in the same cycle
        adr_src = 1'b1; result = 32'h1000; err_clr = 1'b1;
        tick();
        chk("oor_set_wins", 32'(err_oor), 32'h1);
        adr_src = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("oor_clr", 32'(err_oor), 32'h0);

        // Last in-range word
        adr_src = 1'b1; result = 32'hFFC; write_data = 32'h77777777; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        #1 chk("last_rd", read_data, 32'h77777777);
        tick();
        adr_src = 1'b0;
        chk("last_no_oor", 32'(err_oor), 32'h0);

        // Loader out of range sets err_oor
        load(32'h1000, 32'h99999999);
        chk("ld_oor", 32'(err_oor), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // 5. Loader beats a simultaneous store to the same word
        ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'h11111111;
        adr_src = 1'b1; result = 32'h8; write_data = 32'h22222222; mem_write = 1'b1;
        tick();
        ld_en = 1'b0; mem_write = 1'b0; adr_src = 1'b0;
        peek(32'h8, "ld_prio", 32'h11111111);

        // 6. Reset raised before the edge cancels the pending write
        adr_src = 1'b1; result = 32'h10; write_data = 32'hA5A5A5A5;
        mem_write = 1'b1; ir_write = 1'b1;
        #2 rst = 1'b1;
        #1 chk("rstw_instr", instr, 32'h00000013);
        tick();
        mem_write = 1'b0; ir_write = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_mem",   read_data, 32'h12345678);
        chk("rstw_ir",    instr, 32'h00000013);
        chk("rstw_flags", {30'h0, err_misalign, err_oor}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_mem_stage.md
Name: multi_mem_stage

Overview:
Fetch/memory stage of the multicycle RV32I datapath, driven directly by the multicycle controller's AdrSrc, MemWrite and IRWrite outputs.
- Holds the unified instruction/data word memory, the address mux, the instruction register (IR), the OldPC register and the memory data register (MDR).
- Feeds IR opcode/funct fields back to the controller and MDR to the result mux (ResultSrc=01).
- Includes a bench/boot loader port and sticky fault flags.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in memory; power of two, >=4.
NOP_INSTR, 32'h00000013, IR reset value (addi x0,x0,0).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pc  input  32  current PC register value
result  input  32  result-mux output, used as data address
adr_src  input  1  0: address=pc, 1: address=result
mem_write  input  1  write write_data to addressed word this edge
ir_write  input  1  capture read word into IR and pc into old_pc this edge
write_data  input  32  store data (register B)
ld_en  input  1  loader write strobe
ld_addr  input  32  loader byte address
ld_data  input  32  loader word
err_clr  input  1  synchronous clear of fault flags
read_data  output  32  combinational memory read of current address
instr  output  32  IR contents
old_pc  output  32  PC of the instruction held in IR
mdr  output  32  memory data register
err_misalign  output  1  sticky: access with address bits [1:0] != 0
err_oor  output  1  sticky: access beyond DEPTH_WORDS*4

Behaviour:
- Address: adr = adr_src ? result : pc.
- Word index = adr[log2(DEPTH_WORDS)+1:2]; bits [1:0] ignored for indexing.
- Access cycle = any cycle with mem_write=1, ir_write=1 or adr_src=1.
- In-range: adr < DEPTH_WORDS*4 (unsigned).
- Read is combinational: read_data = mem[index] if in range, else 32'h0.
- MDR: mdr <= read_data on every rising edge, no enable. Latency is 1 cycle from address to mdr.
- IR/OldPC: when ir_write=1, instr <= read_data and old_pc <= pc. Otherwise both hold.
- Write: when mem_write=1, in range, ld_en=0 and rst=0, mem[index] <= write_data at the edge.
  - Out-of-range writes are dropped.
- Read during write (same cycle): read_data, mdr and instr see the pre-write contents. The new value is visible the next cycle.
- ir_write and mem_write together: IR captures old contents, write still performed.
- Loader:
  - ld_en=1 writes ld_data to mem[ld_addr index] if in range; otherwise dropped and err_oor set.
  - Loader has priority: a simultaneous mem_write is discarded. IR/MDR behaviour is unchanged.
- Fault flags:
  - err_misalign sets at the edge of any access cycle with adr[1:0] != 0. The access still proceeds using the word index.
  - err_oor sets at the edge of any access cycle with adr out of range.
  - err_clr=1 clears both flags. If a set condition occurs in the same cycle, set wins.
- Reset, asynchronous: instr=NOP_INSTR, old_pc=0, mdr=0, err_misalign=0, err_oor=0.
  - read_data follows memory, which is not cleared by reset.
  - While rst=1, no memory write (user or loader) occurs. A write pending when rst rises mid-cycle is lost.
- Wrap-around: none. Indexing never aliases; out-of-range addresses are faults, not wraps.

Test Plan:
1. Reset then fetch: assert rst mid-cycle -> instr=32'h00000013, old_pc=0, mdr=0, flags 0 immediately. Load word 0=32'h00500093, pc=0, ir_write=1 one edge -> instr=32'h00500093, old_pc=0.
2. Store/load: adr_src=1, result=32'h40, write_data=32'hDEADBEEF, mem_write=1 -> same-cycle read_data=old value. Next cycle read_data=32'hDEADBEEF; following edge mdr=32'hDEADBEEF.
3. Misalign: result=32'h42, adr_src=1 -> reads word 0x40, err_misalign=1 after edge and held. err_clr=1 with a clean address -> 0.
4. Out of range: result=DEPTH_WORDS*4=32'h1000, mem_write=1 -> no memory change, read_data=0, err_oor=1. Repeat with err_clr=1 in same cycle -> err_oor stays 1.
5. Loader priority: ld_en=1 with ld_addr=32'h8, ld_data=32'h11111111, and same cycle mem_write=1 with address 32'h8 and data 32'h22222222 -> word 2 = 32'h11111111.
6. Reset during write: mem_write=1 to 32'h10 with data 32'hA5A5A5A5, rst raised before edge -> word 4 unchanged, IR back to NOP.
